mac_seq: RTL and testbench

//  Parametrised multi-chunk multiply-accumulate engine: successor to the fixed 3x8-bit node MAC in the BDD datapath.

---
 rtl/mac_seq.sv | 171 +++++++++++++++++
 tb/tb_mac_seq.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq.sv
// mac_seq: chunk-serial unsigned multiply-accumulate with a saturating result and valid/ready handshakes.
// Optional bias stage after the last chunk is compiled in when MAC_BIAS_EN is defined.
module mac_seq #(
  parameter int NUM_CHUNKS = 3,
  parameter int CHUNK_W    = 8,
  parameter int ACC_WIDTH  = 20,
  parameter int BIAS_W     = 10,
  localparam int ATTR_WIDTH  = NUM_CHUNKS * CHUNK_W,
`ifdef MAC_BIAS_EN
  localparam int COEFF_WIDTH = NUM_CHUNKS * CHUNK_W + BIAS_W
`else
  localparam int COEFF_WIDTH = NUM_CHUNKS * CHUNK_W
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ATTR_WIDTH-1:0]  in_attr,
  input  logic [COEFF_WIDTH-1:0] in_coeff,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_acc,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int MUL_W = NUM_CHUNKS * CHUNK_W;
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_BIAS = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [ATTR_WIDTH-1:0]  r_attr;
  logic [MUL_W-1:0]       r_coeff;
  logic [IDX_W-1:0]       r_idx;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic                   r_ovf;
  logic                   r_out_valid;
  logic [ACC_WIDTH-1:0]   r_out_acc;
  logic                   r_out_ovf;
`ifdef MAC_BIAS_EN
  logic [BIAS_W-1:0]      r_bias;
  logic [ACC_WIDTH:0]     w_bias_sum;
`endif

  logic                   w_accept;
  logic [2*CHUNK_W-1:0]   w_prod;
  logic [ACC_WIDTH:0]     w_mac_sum;

  // Returns {carry, value}; the value clamps to all-ones when the add carries out.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] acc,
                                                 input logic [ACC_WIDTH-1:0] addend);
    logic [ACC_WIDTH:0] sum;
    sum = {1'b0, acc} + {1'b0, addend};
    if (sum[ACC_WIDTH]) begin
      sat_add = {1'b1, {ACC_WIDTH{1'b1}}};
    end else begin
      sat_add = sum;
    end
  endfunction

  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_acc   = r_out_acc;
  assign out_ovf   = r_out_ovf;

  // Operands are shifted left each MAC cycle so the current chunk is always the top slice.
  assign w_prod    = {{CHUNK_W{1'b0}}, r_attr[ATTR_WIDTH-1 -: CHUNK_W]} *
                     {{CHUNK_W{1'b0}}, r_coeff[MUL_W-1 -: CHUNK_W]};
  assign w_mac_sum = sat_add(r_acc, ACC_WIDTH'(w_prod));
`ifdef MAC_BIAS_EN
  assign w_bias_sum = sat_add(r_acc, ACC_WIDTH'(r_bias));
`endif

  // Operand capture on accept, chunk shift while multiplying.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_attr  <= {ATTR_WIDTH{1'b0}};
      r_coeff <= {MUL_W{1'b0}};
`ifdef MAC_BIAS_EN
      r_bias  <= {BIAS_W{1'b0}};
`endif
    end else if (w_accept) begin
      r_attr  <= in_attr;
      r_coeff <= in_coeff[COEFF_WIDTH-1 -: MUL_W];
`ifdef MAC_BIAS_EN
      r_bias  <= in_coeff[BIAS_W-1:0];
`endif
    end else if (r_state == S_MAC) begin
      r_attr  <= r_attr << CHUNK_W;
      r_coeff <= r_coeff << CHUNK_W;
    end else begin
      r_attr  <= r_attr;
      r_coeff <= r_coeff;
    end
  end

  // Control FSM with accumulator and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= {IDX_W{1'b0}};
      r_acc       <= {ACC_WIDTH{1'b0}};
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= {ACC_WIDTH{1'b0}};
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_state     <= S_MAC;
      r_idx       <= {IDX_W{1'b0}};
      r_acc       <= {ACC_WIDTH{1'b0}};
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_IDLE;
        end
        S_MAC: begin
          r_acc <= w_mac_sum[ACC_WIDTH-1:0];
          r_ovf <= r_ovf | w_mac_sum[ACC_WIDTH];
          r_idx <= r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
`ifdef MAC_BIAS_EN
            r_state     <= S_BIAS;
`else
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_out_acc   <= w_mac_sum[ACC_WIDTH-1:0];
            r_out_ovf   <= r_ovf | w_mac_sum[ACC_WIDTH];
`endif
          end else begin
            r_state <= S_MAC;
          end
        end
`ifdef MAC_BIAS_EN
        S_BIAS: begin
          r_acc       <= w_bias_sum[ACC_WIDTH-1:0];
          r_ovf       <= r_ovf | w_bias_sum[ACC_WIDTH];
          r_state     <= S_DONE;
          r_out_valid <= 1'b1;
          r_out_acc   <= w_bias_sum[ACC_WIDTH-1:0];
          r_out_ovf   <= r_ovf | w_bias_sum[ACC_WIDTH];
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state     <= S_DONE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq: default instance plus a 2-chunk, 16-bit instance for saturation.
`timescale 1ns/1ps
module tb_mac_seq;

  localparam int CW  = 8;
  localparam int BW  = 10;
  localparam int NC1 = 3;
  localparam int AW1 = 20;
  localparam int NC2 = 2;
  localparam int AW2 = 16;
`ifdef MAC_BIAS_EN
  localparam int BEN = 1;
`else
  localparam int BEN = 0;
`endif
  localparam int AT1 = NC1 * CW;
  localparam int CO1 = NC1 * CW + BEN * BW;
  localparam int AT2 = NC2 * CW;
  localparam int CO2 = NC2 * CW + BEN * BW;

  typedef struct packed {
    logic        ovf;
    logic [31:0] acc;
  } exp_t;

  logic clk;
  logic rst;
  logic in_valid1, in_ready1, out_valid1, out_ready1, out_ovf1, busy1;
  logic [AT1-1:0] in_attr1;
  logic [CO1-1:0] in_coeff1;
  logic [AW1-1:0] out_acc1;
  logic in_valid2, in_ready2, out_valid2, out_ready2, out_ovf2, busy2;
  logic [AT2-1:0] in_attr2;
  logic [CO2-1:0] in_coeff2;
  logic [AW2-1:0] out_acc2;

  int   total;
  int   bad;
  int   cyc;
  int   acc_cyc;
  bit   rand_rdy;
  bit   rdy_cmd;
  exp_t q1[$];
  exp_t q2[$];

  mac_seq u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_attr(in_attr1), .in_coeff(in_coeff1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_acc(out_acc1), .out_ovf(out_ovf1), .busy(busy1)
  );

  mac_seq #(.NUM_CHUNKS(NC2), .ACC_WIDTH(AW2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_attr(in_attr2), .in_coeff(in_coeff2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_acc(out_acc2), .out_ovf(out_ovf2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Reference: dot product of MSB-first chunks, clamped after every add, optional bias last.
  function automatic exp_t model(input logic [63:0] attr, input logic [63:0] coeff,
                                 input int nc, input int aw);
    exp_t r;
    longint unsigned sum, maxv, a, c, mask;
    int sh;
    maxv  = (64'd1 << aw) - 64'd1;
    mask  = (64'd1 << CW) - 64'd1;
    sh    = (BEN != 0) ? BW : 0;
    sum   = 64'd0;
    r.ovf = 1'b0;
    for (int i = 0; i < nc; i++) begin
      a = (attr >> ((nc - 1 - i) * CW)) & mask;
      c = (coeff >> (sh + (nc - 1 - i) * CW)) & mask;
      sum = sum + a * c;
      if (sum > maxv) begin
        sum   = maxv;
        r.ovf = 1'b1;
      end
    end
    if (BEN != 0) begin
      sum = sum + (coeff & ((64'd1 << BW) - 64'd1));
      if (sum > maxv) begin
        sum   = maxv;
        r.ovf = 1'b1;
      end
    end
    r.acc = 32'(sum);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic send1(input logic [AT1-1:0] a, input logic [CO1-1:0] c, input exp_t e);
    logic ok;
    ok = 1'b0;
    in_attr1  = a;
    in_coeff1 = c;
    in_valid1 = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready1;
      @(posedge clk);
      #1;
    end
    in_valid1 = 1'b0;
    if (ok) begin
      q1.push_back(e);
      acc_cyc = cyc;
    end else begin
      check("dut1_accept_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic send2(input logic [AT2-1:0] a, input logic [CO2-1:0] c, input exp_t e);
    logic ok;
    ok = 1'b0;
    in_attr2  = a;
    in_coeff2 = c;
    in_valid2 = 1'b1;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready2;
      @(posedge clk);
      #1;
    end
    in_valid2 = 1'b0;
    if (ok) begin
      q2.push_back(e);
    end else begin
      check("dut2_accept_timeout", 64'd0, 64'd1);
    end
  endtask

  // out_ready for the default instance: directed value or random backpressure.
  initial begin
    out_ready1 = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready1 = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_cmd;
    end
  end

  // Monitors: pop one expectation per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid1 && out_ready1) begin
        if (q1.size() == 0) begin
          check("dut1_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = q1.pop_front();
          check("dut1_acc", 64'(out_acc1), 64'(e.acc));
          check("dut1_ovf", 64'(out_ovf1), 64'(e.ovf));
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid2 && out_ready2) begin
        if (q2.size() == 0) begin
          check("dut2_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = q2.pop_front();
          check("dut2_acc", 64'(out_acc2), 64'(e.acc));
          check("dut2_ovf", 64'(out_ovf2), 64'(e.ovf));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [AT1-1:0] a1, ta;
    logic [CO1-1:0] c1, tc;
    logic [63:0]    rnd;
    logic [AT2-1:0] a2;
    logic [CO2-1:0] c2;
    exp_t           e, e_t1;
    int             c_first, seen;
    total = 0; bad = 0; acc_cyc = 0;
    rand_rdy = 1'b0; rdy_cmd = 1'b1;
    rst = 1'b1;
    in_valid1 = 1'b0; in_attr1 = '0; in_coeff1 = '0;
    in_valid2 = 1'b0; in_attr2 = '0; in_coeff2 = '0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready", 64'(in_ready1), 64'd1);
    check("rst_out_valid", 64'(out_valid1), 64'd0);
    check("rst_out_acc", 64'(out_acc1), 64'd0);
    check("rst_out_ovf", 64'(out_ovf1), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);

    // Directed job: 1*4 + 2*5 + 3*6 (plus bias 0x3FF when enabled).
    ta = 24'h010203;
`ifdef MAC_BIAS_EN
    tc = {24'h040506, 10'h3FF};
    e_t1 = '{ovf: 1'b0, acc: 32'd1055};
`else
    tc = 24'h040506;
    e_t1 = '{ovf: 1'b0, acc: 32'd32};
`endif
    send1(ta, tc, e_t1);
    check("mac_busy", 64'(busy1), 64'd1);
    check("mac_in_ready", 64'(in_ready1), 64'd0);
    repeat (NC1 + BEN - 1) @(posedge clk);
    #1 check("latency_not_yet", 64'(out_valid1), 64'd0);
    @(posedge clk);
    #1 check("latency_valid", 64'(out_valid1), 64'd1);

    // Back-to-back: second accept on the edge the first result is taken.
    send1(ta, tc, e_t1);
    c_first = acc_cyc;
    rnd = {$urandom, $urandom};
    a1 = AT1'(rnd);
    c1 = CO1'({$urandom, $urandom});
    send1(a1, c1, model(64'(a1), 64'(c1), NC1, AW1));
    check("b2b_gap", 64'(acc_cyc - c_first), 64'(NC1 + 1 + BEN));

    for (int n = 0; n < 50 && q1.size() != 0; n++) @(posedge clk);
    #1;

    // Backpressure: hold the result for 5 cycles.
    rdy_cmd = 1'b0;
    @(posedge clk);
    #1;
    a1 = AT1'($urandom);
    c1 = CO1'({$urandom, $urandom});
    e  = model(64'(a1), 64'(c1), NC1, AW1);
    send1(a1, c1, e);
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(negedge clk);
      if (out_valid1) seen = 1;
    end
    check("bp_valid_seen", 64'(seen), 64'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", 64'(out_valid1), 64'd1);
      check("bp_hold_acc", 64'(out_acc1), 64'(e.acc));
      check("bp_in_ready", 64'(in_ready1), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rdy_cmd = 1'b1;
    @(posedge clk);
    #3 check("bp_one_beat", 64'(out_valid1), 64'd0);

    // Reset while idx==1 aborts the job.
    @(posedge clk);
    #1;
    send1(ta, tc, e_t1);
    @(posedge clk);
    #1 rst = 1'b1;
    q1.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_in_ready", 64'(in_ready1), 64'd1);
    check("abort_out_valid", 64'(out_valid1), 64'd0);
    check("abort_out_acc", 64'(out_acc1), 64'd0);
    check("abort_busy", 64'(busy1), 64'd0);
    seen = 0;
    for (int n = 0; n < NC1 + 3; n++) begin
      @(negedge clk);
      if (out_valid1) seen = 1;
    end
    check("abort_no_valid", 64'(seen), 64'd0);
    @(posedge clk);
    #1 send1(ta, tc, e_t1);

    // Random jobs with random gaps and random backpressure.
    rand_rdy = 1'b1;
    for (int j = 0; j < 40; j++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      a1 = AT1'($urandom);
      c1 = CO1'({$urandom, $urandom});
      if ($urandom_range(0, 4) == 0) a1[AT1-1 -: CW] = 8'hFF;
      send1(a1, c1, model(64'(a1), 64'(c1), NC1, AW1));
    end
    @(posedge clk);
    #1 rand_rdy = 1'b0;
    rdy_cmd = 1'b1;

    // Narrow instance: saturation, then a clean job afterwards.
`ifdef MAC_BIAS_EN
    send2(16'hFFFF, {16'hFFFF, 10'h000}, '{ovf: 1'b1, acc: 32'h0000FFFF});
    send2(16'h0101, {16'h0101, 10'h000}, '{ovf: 1'b0, acc: 32'd2});
`else
    send2(16'hFFFF, 16'hFFFF, '{ovf: 1'b1, acc: 32'h0000FFFF});
    send2(16'h0101, 16'h0101, '{ovf: 1'b0, acc: 32'd2});
`endif
    for (int j = 0; j < 20; j++) begin
      a2 = AT2'($urandom);
      c2 = CO2'($urandom);
      send2(a2, c2, model(64'(a2), 64'(c2), NC2, AW2));
    end

    for (int n = 0; n < 200 && (q1.size() != 0 || q2.size() != 0); n++) @(posedge clk);
    #1;
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
